alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
Initiator-side controller for the 4-bit combinational ALU. Accepts operation commands over a valid/ready handshake, drives registered opcode/operands to the ALU, and captures the ALU result. It keeps an accumulator so commands can be chained, and returns each result over a second valid/ready handshake. Sits between the command source (top-level control / test stimulus) and the ALU instance.

Parameters:
DATA_W, 4, operand/result width; must match ALU width.
ACC_INIT, 0, accumulator value after reset and after acc_clear.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_oc  in  3  opcode; same encoding as the ALU: 000 add, 001 sub, 010 mul, 011 div, 100 not, 101 xor, 110 or, 111 and.
cmd_a  in  DATA_W  operand A.
cmd_b  in  DATA_W  operand B.
cmd_use_acc  in  1  1: use accumulator as A and ignore cmd_a.
acc_clear  in  1  synchronous accumulator clear.
alu_oc  out  3  opcode to ALU.
alu_a  out  DATA_W  operand A to ALU.
alu_b  out  DATA_W  operand B to ALU.
alu_f  in  DATA_W  ALU result (combinational from alu_*).
res_valid  out  1  result present.
res_ready  in  1  consumer accepts result.
res_data  out  DATA_W  captured result.
res_err  out  1  error flag for this result (see Optional Feature).
acc  out  DATA_W  current accumulator value.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, cmd_ready=0 while asserted, res_valid=0, res_data=0, res_err=0, alu_oc=0, alu_a=0, alu_b=0, acc=ACC_INIT. An in-flight command is discarded. cmd_ready rises in the first cycle after rst_n deasserts.
- FSM states: IDLE, ISSUE, DONE.
- IDLE: cmd_ready=1. Handshake when cmd_valid & cmd_ready at a rising edge. Register alu_oc=cmd_oc and alu_b=cmd_b. Register alu_a=(cmd_use_acc ? acc : cmd_a). Go to ISSUE.
- ISSUE (exactly 1 cycle): cmd_ready=0. At the end of the cycle, capture res_data=alu_f and acc=alu_f. Set res_valid=1 and go to DONE.
- DONE: res_valid=1, cmd_ready=0. res_data and res_err stay stable until res_valid & res_ready. On handshake: res_valid=0, go to IDLE. No same-cycle accept of a new command.
- Latency: command accept edge N. res_valid is high from edge N+2. Throughput is at most 1 result per 3 cycles with res_ready held at 1.
- alu_* outputs hold their last issued values in IDLE/DONE. They change only on command accept.
- Arithmetic: all results wrap modulo 2^DATA_W, exactly as the ALU produces them. The sequencer performs no arithmetic of its own.
- acc_clear in IDLE, when a command with cmd_use_acc=1 is accepted in the same cycle: the clear takes priority, and alu_a=ACC_INIT.
- acc_clear in ISSUE: ignored. The capture writes acc.
- acc_clear in DONE: acc=ACC_INIT. res_data is unaffected.
- cmd_* inputs are ignored unless accepted. res_ready is ignored unless res_valid=1.

Optional Feature:
Macro ALU_DIVZERO_GUARD_EN.
- Defined: a command accepted with cmd_oc=011 and effective B=0 still goes through ISSUE. At capture, res_data and acc are set to all-ones (4'hF) instead of alu_f, and res_err=1. res_err=0 for every other result.
- Not defined: res_err is constant 0, and division by zero captures whatever alu_f returns.

Test Plan:
- Add: oc=000, a=3, b=5, use_acc=0, res_ready=1 -> res_valid at accept+2, res_data=8, acc=8, res_err=0.
- Wrap/chain: oc=010, a=7, b=3 -> res_data=4'h5. Then oc=001, use_acc=1, b=7 -> alu_a=5, res_data=4'hE.
- Backpressure: oc=101, a=4'hA, b=4'h6, res_ready=0 for 5 cycles -> res_valid=1 and res_data=4'hC held stable, cmd_ready=0 throughout. res_ready=1 -> IDLE next cycle, cmd_ready=1.
- Clear priority: acc=9, acc_clear=1 with oc=110, use_acc=1, b=2 in the same cycle -> alu_a=0, res_data=2.
- Divide by zero: oc=011, a=6, b=0 -> with ALU_DIVZERO_GUARD_EN: res_data=4'hF, res_err=1, acc=4'hF. Without it: res_err=0, res_data=alu_f.
- Reset mid-operation: accept oc=000, a=1, b=1, assert rst_n=0 during ISSUE -> immediately res_valid=0, alu_*=0, acc=ACC_INIT. After release, no result is ever presented, and cmd_ready=1 one cycle after rst_n rises.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the 4-bit combinational ALU, with a chaining accumulator.
// Optional divide-by-zero guard enabled by defining ALU_DIVZERO_GUARD_EN.
module alu_cmd_sequencer #(
  parameter int                 DATA_W   = 4,
  parameter logic [DATA_W-1:0]  ACC_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_oc,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  input  logic              acc_clear,
  output logic [2:0]        alu_oc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_f,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic [DATA_W-1:0] acc
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state_q, state_d;
  logic              run_q;
  logic              accept;
  logic              div_zero;
  logic [DATA_W-1:0] cap_val;

  // run_q keeps cmd_ready low until the first clock after reset release
  assign cmd_ready = run_q && (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef ALU_DIVZERO_GUARD_EN
  assign div_zero = (alu_oc == 3'b011) && (alu_b == '0);
`else
  assign div_zero = 1'b0;
`endif

  assign cap_val = div_zero ? '1 : alu_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      alu_oc   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      acc      <= ACC_INIT;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (acc_clear) acc <= ACC_INIT;
          if (accept) begin
            alu_oc <= cmd_oc;
            alu_b  <= cmd_b;
            // a same-cycle clear wins over the stale accumulator value
            alu_a  <= cmd_use_acc ? (acc_clear ? ACC_INIT : acc) : cmd_a;
          end
        end
        ISSUE: begin
          res_data <= cap_val;
          acc      <= cap_val;
          res_err  <= div_zero;
        end
        DONE: begin
          if (acc_clear) acc <= ACC_INIT;
        end
        default: ;
      endcase
    end
  end

endmodule
